// File: rtl/cpu4_sequencer_pkg.sv
// Shared types and constants for the 4-bit CPU sequencer: FSM states, opcode
// constants and instruction-word field helpers.
package cpu4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_FAULT
    } state_t;

    localparam logic [3:0] OPC_JNZ    = 4'b0011;
    localparam logic [3:0] OPC_LD     = 4'b1111;
    localparam logic [3:0] OPC_NOWB_A = 4'b1000;
    localparam logic [3:0] OPC_NOWB_B = 4'b0100;

    // Opcode groups by opcode[3:2]
    localparam logic [1:0] GRP_CTRL = 2'b00;
    localparam logic [1:0] GRP_IMM  = 2'b01;

    function automatic logic [3:0] ir_opc(input logic [7:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [3:0] ir_opd(input logic [7:0] ir);
        return ir[3:0];
    endfunction

endpackage

// File: rtl/cpu4_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer (master)
// and the memory side (slave).
interface cpu4_sequencer_if #(
    parameter int PC_W = 4
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [7:0]      imem_data;
    logic            dmem_req;
    logic [3:0]      dmem_addr;
    logic            dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_addr,
        input  imem_ack, imem_data, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_addr,
        output imem_ack, imem_data, dmem_ack
    );
endinterface

// File: rtl/cpu4_sequencer_decode.sv
// Combinational instruction decode: IR -> datapath selects, write-back enable
// and jump condition.
module cpu4_decode
    import cpu4_pkg::*;
(
    input  logic [7:0] i_ir,
    input  logic       i_zf,
    input  logic       i_sf,
    output logic [1:0] o_alu_op,
    output logic       o_imm_sel,
    output logic       o_ld_sel,
    output logic       o_flag_en,
    output logic       o_wb_en,
    output logic       o_jmp_cond
);
    logic [3:0] w_opc;

    assign w_opc      = ir_opc(i_ir);
    assign o_alu_op   = w_opc[1:0];
    assign o_imm_sel  = (w_opc[3:2] == GRP_IMM);
    assign o_ld_sel   = (w_opc == OPC_LD);
    // Control group and loads leave the flag register untouched
    assign o_flag_en  = (w_opc[3:2] != GRP_CTRL) && (w_opc != OPC_LD);
    assign o_wb_en    = !((w_opc == OPC_NOWB_A) || (w_opc == OPC_NOWB_B) ||
                          (w_opc[3:2] == GRP_CTRL));
    assign o_jmp_cond = (w_opc == OPC_JNZ) && !i_zf && !i_sf;

endmodule

// File: rtl/cpu4_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-bit CPU.
// Optional single-step input enabled by defining CPU4_SEQ_STEP_EN.
module cpu4_sequencer
    import cpu4_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int MEM_TO = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
`ifdef CPU4_SEQ_STEP_EN
    input  logic                   step,
`endif
    cpu4_sequencer_if.master       bus,
    input  logic                   zf,
    input  logic                   sf,
    input  logic                   cf,
    output logic [1:0]             alu_op,
    output logic                   imm_sel,
    output logic                   ld_sel,
    output logic                   reg_we,
    output logic                   flag_we,
    output logic [PC_W-1:0]        pc,
    output logic                   busy,
    output logic                   fault
);
    localparam int TO_W = (MEM_TO > 0) ? $clog2(MEM_TO + 1) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [PC_W-1:0]   r_pc;
    logic [7:0]        r_ir;
    logic [TO_W-1:0]   r_wait;
    logic              r_jmp;
    logic              r_single;
    logic              w_start;
    logic              w_ack;
    logic              w_waiting;
    logic              w_timeout;
    logic              w_flag_en;
    logic              w_wb_en;
    logic              w_jmp_cond;
    logic              w_unused;

    // Carry flag is part of the flag bus but plays no role in sequencing
    assign w_unused = cf;

    cpu4_decode u_decode (
        .i_ir       (r_ir),
        .i_zf       (zf),
        .i_sf       (sf),
        .o_alu_op   (alu_op),
        .o_imm_sel  (imm_sel),
        .o_ld_sel   (ld_sel),
        .o_flag_en  (w_flag_en),
        .o_wb_en    (w_wb_en),
        .o_jmp_cond (w_jmp_cond)
    );

`ifdef CPU4_SEQ_STEP_EN
    assign w_start = run || step;
`else
    assign w_start = run;
`endif

    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_ack     = (r_state == ST_FETCH) ? bus.imem_ack : bus.dmem_ack;
    assign w_timeout = (MEM_TO > 0) && (r_wait == TO_W'(MEM_TO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_FETCH;
            ST_FETCH:  if (bus.imem_ack) w_next = ST_DECODE;
                       else if (w_timeout) w_next = ST_FAULT;
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC:   w_next = ld_sel ? ST_MEM : ST_WB;
            ST_MEM:    if (bus.dmem_ack) w_next = ST_WB;
                       else if (w_timeout) w_next = ST_FAULT;
            ST_WB:     w_next = (run && !r_single) ? ST_FETCH : ST_IDLE;
            ST_FAULT:  w_next = ST_FAULT;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req = (r_state == ST_FETCH);
        bus.dmem_req = (r_state == ST_MEM);
        flag_we      = (r_state == ST_EXEC) && w_flag_en;
        reg_we       = (r_state == ST_WB) && w_wb_en;
        busy         = (r_state != ST_IDLE) && (r_state != ST_FAULT);
        fault        = (r_state == ST_FAULT);
    end

    assign bus.imem_addr = r_pc;
    assign bus.dmem_addr = ir_opd(r_ir);
    assign pc            = r_pc;

    // Jump decision is frozen in EXEC so the instruction's own flag update cannot affect it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_ir     <= 8'h00;
            r_wait   <= '0;
            r_jmp    <= 1'b0;
            r_single <= 1'b0;
        end else begin
            if ((r_state == ST_FETCH) && bus.imem_ack) r_ir <= bus.imem_data;
            if (r_state == ST_EXEC) r_jmp <= w_jmp_cond;
            if (r_state == ST_WB)
                r_pc <= r_jmp ? PC_W'(ir_opd(r_ir)) : r_pc + PC_W'(1);
            if (w_waiting && !w_ack && (MEM_TO > 0)) r_wait <= r_wait + TO_W'(1);
            else                                     r_wait <= '0;
`ifdef CPU4_SEQ_STEP_EN
            if (r_state == ST_IDLE) r_single <= step;
`endif
        end
    end

endmodule

// File: tb/tb_cpu4_sequencer.sv
// Self-checking bench for cpu4_sequencer: instruction-level timeline model
// compared every cycle, plus literal spot checks.
module tb_cpu4_sequencer;
    localparam int PC_W   = 4;
    localparam int MEM_TO = 15;

    typedef struct packed {
        logic       ireq;
        logic [3:0] iaddr;
        logic       dreq;
        logic [3:0] daddr;
        logic [1:0] aop;
        logic       imm;
        logic       ld;
        logic       rwe;
        logic       fwe;
        logic [3:0] pc;
        logic       busy;
        logic       fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic zf = 1'b0, sf = 1'b0, cf = 1'b0;
    logic [1:0] alu_op;
    logic imm_sel, ld_sel, reg_we, flag_we, busy, fault;
    logic [PC_W-1:0] pc;
`ifdef CPU4_SEQ_STEP_EN
    logic step = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    logic exp_on = 1'b0;
    exp_t exp_v;

    logic [3:0] m_pc;
    logic [7:0] m_ir;
    logic       m_idle;

    always #5 clk = ~clk;

    cpu4_sequencer_if #(.PC_W(PC_W)) bus ();

    cpu4_sequencer #(.PC_W(PC_W), .MEM_TO(MEM_TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
`ifdef CPU4_SEQ_STEP_EN
        .step    (step),
`endif
        .bus     (bus.master),
        .zf      (zf),
        .sf      (sf),
        .cf      (cf),
        .alu_op  (alu_op),
        .imm_sel (imm_sel),
        .ld_sel  (ld_sel),
        .reg_we  (reg_we),
        .flag_we (flag_we),
        .pc      (pc),
        .busy    (busy),
        .fault   (fault)
    );

    function automatic exp_t dut_vec();
        exp_t a;
        a.ireq = bus.imem_req;  a.iaddr = bus.imem_addr;
        a.dreq = bus.dmem_req;  a.daddr = bus.dmem_addr;
        a.aop = alu_op; a.imm = imm_sel; a.ld = ld_sel;
        a.rwe = reg_we; a.fwe = flag_we; a.pc = pc;
        a.busy = busy;  a.fault = fault;
        return a;
    endfunction

    // Expected outputs with no strobes/requests, from the architectural PC and IR
    function automatic exp_t model_base(input logic b);
        exp_t e;
        logic [3:0] opc;
        opc = m_ir[7:4];
        e = '0;
        e.iaddr = m_pc;
        e.daddr = m_ir[3:0];
        e.aop   = opc[1:0];
        e.imm   = (opc[3:2] == 2'b01);
        e.ld    = (opc == 4'hF);
        e.pc    = m_pc;
        e.busy  = b;
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_on) begin
            exp_t a;
            a = dut_vec();
            checks++;
            if (a !== exp_v) begin
                failures++;
                $display("FAIL cycle_model t=%0t actual=%06h required=%06h", $time, a, exp_v);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input exp_t e);
        exp_v  = e;
        exp_on = 1'b1;
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input logic r);
        run = r;
        bus.imem_ack = 1'($urandom);
        bus.dmem_ack = 1'($urandom);
        cyc(model_base(1'b0));
    endtask

    task automatic fault_cycles();
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            run = 1'($urandom);
            bus.imem_ack = 1'($urandom);
            bus.dmem_ack = 1'($urandom);
            e = model_base(1'b0);
            e.fault = 1'b1;
            cyc(e);
        end
        check_lit("fault_flag", 32'(fault), 32'd1);
        check_lit("fault_imem_req", 32'(bus.imem_req), 32'd0);
        check_lit("fault_dmem_req", 32'(bus.dmem_req), 32'd0);
    endtask

    // One instruction's full timeline; hang=1/2 withholds imem/dmem ack until timeout
    task automatic do_instr(input logic [7:0] ins, input int di, input int dd,
                            input logic z, input logic s, input logic run_wb, input int hang);
        exp_t e;
        logic [3:0] opc;
        logic jmp;
        int nf, nm;
        opc = ins[7:4];
        jmp = (opc == 4'b0011) && !z && !s;
        nf  = (hang == 1) ? MEM_TO : di + 1;
        for (int k = 0; k < nf; k++) begin
            run = 1'($urandom); zf = 1'($urandom); sf = 1'($urandom);
            bus.dmem_ack  = 1'($urandom);
            bus.imem_ack  = (hang != 1) && (k == nf - 1);
            bus.imem_data = bus.imem_ack ? ins : 8'($urandom);
            e = model_base(1'b1);
            e.ireq = 1'b1;
            cyc(e);
        end
        bus.imem_ack = 1'b0;
        if (hang == 1) begin
            fault_cycles();
            return;
        end
        m_ir = ins;
        run = 1'($urandom); bus.imem_ack = 1'($urandom);
        cyc(model_base(1'b1));
        zf = z; sf = s; run = 1'($urandom);
        e = model_base(1'b1);
        e.fwe = (opc[3:2] != 2'b00) && (opc != 4'hF);
        cyc(e);
        zf = 1'($urandom); sf = 1'($urandom);
        if (opc == 4'hF) begin
            nm = (hang == 2) ? MEM_TO : dd + 1;
            for (int k = 0; k < nm; k++) begin
                run = 1'($urandom);
                bus.imem_ack = 1'($urandom);
                bus.dmem_ack = (hang != 2) && (k == nm - 1);
                e = model_base(1'b1);
                e.dreq = 1'b1;
                cyc(e);
            end
            bus.dmem_ack = 1'b0;
            if (hang == 2) begin
                fault_cycles();
                return;
            end
        end
        run = run_wb;
        bus.imem_ack = 1'($urandom); bus.dmem_ack = 1'($urandom);
        e = model_base(1'b1);
        e.rwe = !((opc == 4'h8) || (opc == 4'h4) || (opc[3:2] == 2'b00));
        cyc(e);
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        m_pc = jmp ? ins[3:0] : m_pc + 4'd1;
    endtask

    task automatic do_reset();
        exp_on = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_lit("async_reset", 32'(dut_vec()), 32'd0);
        m_pc = 4'h0; m_ir = 8'h00; run = 1'b0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bus.imem_ack = 1'b0; bus.imem_data = 8'h00; bus.dmem_ack = 1'b0;
        m_pc = 4'h0; m_ir = 8'h00; m_idle = 1'b1;
        #3 check_lit("reset_state", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        idle_cyc(1'b0);
        idle_cyc(1'b1);
        do_instr(8'h51, 0, 0, 1'b0, 1'b0, 1'b1, 0);
        check_lit("pc_after_51", 32'(pc), 32'h1);
        check_lit("alu_op_51", 32'(alu_op), 32'h1);
        check_lit("imm_sel_51", 32'(imm_sel), 32'h1);
        do_instr(8'h3A, 0, 0, 1'b0, 1'b0, 1'b1, 0);
        check_lit("jnz_taken_pc", 32'(pc), 32'hA);
        do_instr(8'h3A, 1, 0, 1'b1, 1'b0, 1'b1, 0);
        check_lit("jnz_not_taken_pc", 32'(pc), 32'hB);
        c0 = cyc_n;
        do_instr(8'hF7, 0, 3, 1'b0, 1'b0, 1'b1, 0);
        check_lit("load_cycles", 32'(cyc_n - c0), 32'd8);
        check_lit("ld_sel_F7", 32'(ld_sel), 32'h1);
        do_instr(8'h3F, 0, 0, 1'b0, 1'b0, 1'b1, 0);
        check_lit("jump_to_F", 32'(pc), 32'hF);
        do_instr(8'h51, 2, 0, 1'b0, 1'b0, 1'b0, 0);
        check_lit("pc_wrap", 32'(pc), 32'h0);
        check_lit("stop_busy", 32'(busy), 32'h0);
        idle_cyc(1'b0);

`ifdef CPU4_SEQ_STEP_EN
        step = 1'b1;
        idle_cyc(1'b0);
        step = 1'b0;
        do_instr(8'h52, 0, 0, 1'b0, 1'b0, 1'b1, 0);
        idle_cyc(1'b0);
        idle_cyc(1'b0);
        check_lit("step_pc", 32'(pc), 32'h1);
        check_lit("step_idle", 32'(busy), 32'h0);
`endif

        m_idle = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [7:0] ins;
            int di, dd, sel;
            logic rw;
            if (m_idle) begin
                repeat ($urandom_range(0, 2)) idle_cyc(1'b0);
                idle_cyc(1'b1);
            end
            sel = $urandom_range(0, 3);
            ins = 8'($urandom);
            if (sel == 0) ins[7:4] = 4'h3;
            if (sel == 1) ins[7:4] = 4'hF;
            di = ($urandom_range(0, 9) == 0) ? MEM_TO - 1 : $urandom_range(0, 3);
            dd = ($urandom_range(0, 9) == 0) ? MEM_TO - 1 : $urandom_range(0, 3);
            rw = ($urandom_range(0, 5) != 0);
            do_instr(ins, di, dd, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, rw, 0);
            m_idle = !rw;
        end

        // Reset while a fetch request is pending
        if (m_idle) idle_cyc(1'b1);
        begin
            exp_t e;
            bus.imem_ack = 1'b0;
            e = model_base(1'b1);
            e.ireq = 1'b1;
            cyc(e);
        end
        do_reset();

        idle_cyc(1'b1);
        do_instr(8'h51, 0, 0, 1'b0, 1'b0, 1'b1, 1);
        do_reset();
        idle_cyc(1'b1);
        do_instr(8'hF3, 0, 0, 1'b0, 1'b0, 1'b1, 2);
        do_reset();
        idle_cyc(1'b0);

        exp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
